// File: rtl/program_load_controller.sv
// Boot sequencer: copies a program image from boot ROM into main memory
// with the CPU held in reset, then releases it. Optional image checksum (LOAD_CHECKSUM_EN).
module program_load_controller #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          PROG_WORDS   = 256,
    parameter logic [31:0] LOAD_BASE    = 32'h0000_0000,
    parameter int          START_DELAY  = 4,
    parameter logic [31:0] EXPECTED_SUM = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reload,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_rdata,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [31:0]           mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  cpu_rst_n,
    output logic                  loading_complete,
    output logic [ADDR_WIDTH-1:0] load_count,
    output logic                  checksum_error
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic [31:0]           DELAY = 32'(START_DELAY);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(PROG_WORDS - 1);

    state_t                state;
    logic [31:0]           delay_cnt;
    logic [ADDR_WIDTH-1:0] index;
    logic                  sum_ok;

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] acc;
    logic [31:0] done_sum;
    // The last word's data is added in the same edge that enters DONE.
    assign done_sum = (state == WRITE) ? acc + mem_wr_data : acc;
    assign sum_ok   = (done_sum == EXPECTED_SUM);
`else
    assign sum_ok         = 1'b1;
    assign checksum_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            delay_cnt        <= '0;
            index            <= '0;
            load_count       <= '0;
            rom_rd_en        <= 1'b0;
            rom_addr         <= '0;
            mem_wr_valid     <= 1'b0;
            mem_wr_addr      <= LOAD_BASE;
            mem_wr_data      <= '0;
            cpu_rst_n        <= 1'b0;
            loading_complete <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            acc              <= '0;
            checksum_error   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (delay_cnt == DELAY) begin
                        if (PROG_WORDS == 0) begin
                            state            <= DONE;
                            loading_complete <= 1'b1;
                            cpu_rst_n        <= sum_ok;
`ifdef LOAD_CHECKSUM_EN
                            checksum_error   <= !sum_ok;
`endif
                        end else begin
                            state     <= READ;
                            rom_rd_en <= 1'b1;
                            rom_addr  <= index;
                        end
                    end else begin
                        delay_cnt <= delay_cnt + 32'd1;
                    end
                end
                READ: begin
                    rom_rd_en <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    mem_wr_data  <= rom_rdata;
                    mem_wr_addr  <= LOAD_BASE + (32'(index) << 2);
                    mem_wr_valid <= 1'b1;
                    state        <= WRITE;
                end
                WRITE: begin
                    if (mem_wr_ready) begin
                        mem_wr_valid <= 1'b0;
                        load_count   <= load_count + 1'b1;
`ifdef LOAD_CHECKSUM_EN
                        acc          <= acc + mem_wr_data;
`endif
                        if (index == LAST) begin
                            state            <= DONE;
                            loading_complete <= 1'b1;
                            cpu_rst_n        <= sum_ok;
`ifdef LOAD_CHECKSUM_EN
                            checksum_error   <= !sum_ok;
`endif
                        end else begin
                            index     <= index + 1'b1;
                            rom_rd_en <= 1'b1;
                            rom_addr  <= index + 1'b1;
                            state     <= READ;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state            <= IDLE;
                        loading_complete <= 1'b0;
                        cpu_rst_n        <= 1'b0;
                        index            <= '0;
                        load_count       <= '0;
                        delay_cnt        <= '0;
`ifdef LOAD_CHECKSUM_EN
                        acc              <= '0;
                        checksum_error   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
